// File: rtl/heu_lanes.sv
// rtl/heu_lanes.sv - lane-parallel histogram equalisation of one ROWS x COLS frame
//
// Purpose:
//   Captures a frame, builds its histogram LANES pixels per cycle, prefix-sums
//   the histogram into a CDF one bin per cycle, then remaps every pixel to
//   floor(cdf[p] * (2^PIX_W-1) / NPIX) LANES pixels per cycle. The result is
//   held on q with out_ready high until the downstream stage accepts it.
//
// Optional feature macro: HEU_BYPASS_EN (adds the bypass port; a start with
//   bypass=1 copies d straight to q and finishes in one edge).
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   ipgu_out_ready in   start strobe; d is valid in the same cycle
//   rdn_in_ready   in   downstream accepts q while out_ready is high
//   d              in   input frame, [ROWS-1:0][COLS-1:0][PIX_W-1:0]
//   bypass         in   (HEU_BYPASS_EN only) sampled together with a start
//   in_ready       out  idle, a start will be taken
//   out_ready      out  q holds a complete result
//   q              out  equalised frame, registered
module heu_lanes #(
  parameter int PIX_W = 8,
  parameter int ROWS  = 5,
  parameter int COLS  = 80,
  parameter int LANES = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ipgu_out_ready,
  input  logic                                 rdn_in_ready,
  input  logic [ROWS-1:0][COLS-1:0][PIX_W-1:0] d,
`ifdef HEU_BYPASS_EN
  input  logic                                 bypass,
`endif
  output logic                                 in_ready,
  output logic                                 out_ready,
  output logic [ROWS-1:0][COLS-1:0][PIX_W-1:0] q
);

  localparam int BINS   = 1 << PIX_W;
  localparam int NPIX   = ROWS * COLS;
  localparam int GROUPS = NPIX / LANES;
  localparam int CNT_W  = $clog2(NPIX + 1);
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LC_W   = $clog2(LANES + 1);
  localparam int PROD_W = CNT_W + PIX_W;

  localparam logic [PROD_W-1:0] MAXV   = PROD_W'(BINS - 1);
  localparam logic [PROD_W-1:0] NPIX_P = PROD_W'(NPIX);
  localparam logic [GRP_W-1:0]  LAST_G = GRP_W'(GROUPS - 1);
  localparam logic [PIX_W-1:0]  LAST_B = PIX_W'(BINS - 1);

  generate
    if (NPIX % LANES != 0) begin : g_bad_lanes
      $error("heu_lanes: LANES must divide ROWS*COLS");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIST,
    S_CDF,
    S_MAP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  // Frame and result are kept in flat idx = r*COLS + c order; the packed
  // layout of d/q already places element [r][c] at that flat position.
  logic [NPIX-1:0][PIX_W-1:0] d_flat;
  logic [NPIX-1:0][PIX_W-1:0] frame;
  logic [NPIX-1:0][PIX_W-1:0] q_flat;

  logic [BINS-1:0][CNT_W-1:0] hist;
  logic [BINS-1:0][CNT_W-1:0] cdf;
  logic [CNT_W-1:0]           acc;
  logic [GRP_W-1:0]           grp;
  logic [PIX_W-1:0]           bin;
  logic                       start_bypass;

  logic [LANES-1:0][IDX_W-1:0]  lane_idx;
  logic [LANES-1:0][PIX_W-1:0]  lane_pix;
  logic [LANES-1:0][PROD_W-1:0] lane_prod;
  logic [LANES-1:0][PIX_W-1:0]  lane_map;
  logic [BINS-1:0][LC_W-1:0]    lane_cnt;

  assign d_flat = d;
  assign q      = q_flat;

`ifdef HEU_BYPASS_EN
  assign start_bypass = bypass;
`else
  assign start_bypass = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and handshake outputs. Starts are only looked at in IDLE,
  // so a start that coincides with the DONE->IDLE edge is dropped.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_ready = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (ipgu_out_ready) begin
          state_n = start_bypass ? S_DONE : S_HIST;
        end
      end
      S_HIST: begin
        if (grp == LAST_G) begin
          state_n = S_CDF;
        end
      end
      S_CDF: begin
        if (bin == LAST_B) begin
          state_n = S_MAP;
        end
      end
      S_MAP: begin
        if (grp == LAST_G) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        out_ready = 1'b1;
        if (rdn_in_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Lane datapath shared by HIST and MAP: both walk the same group counter.
  // lane_cnt gives, per bin, how many lanes of the current group hit it, so
  // several lanes landing in one bin are all counted in a single cycle.
  always_comb begin
    lane_idx  = '0;
    lane_pix  = '0;
    lane_prod = '0;
    lane_map  = '0;
    lane_cnt  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l]  = IDX_W'(grp) * IDX_W'(LANES) + IDX_W'(l);
      lane_pix[l]  = frame[lane_idx[l]];
      lane_prod[l] = PROD_W'(cdf[lane_pix[l]]) * MAXV;
      lane_map[l]  = PIX_W'(lane_prod[l] / NPIX_P);
    end
    for (int b = 0; b < BINS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_pix[l] == PIX_W'(b)) begin
          lane_cnt[b] = lane_cnt[b] + LC_W'(1);
        end
      end
    end
  end

  // Frame, histogram, CDF and result storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame  <= '0;
      q_flat <= '0;
      hist   <= '0;
      cdf    <= '0;
      acc    <= '0;
      grp    <= '0;
      bin    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ipgu_out_ready) begin
            if (start_bypass) begin
              q_flat <= d_flat;
            end else begin
              frame <= d_flat;
              hist  <= '0;
              acc   <= '0;
              grp   <= '0;
              bin   <= '0;
            end
          end
        end
        S_HIST: begin
          for (int b = 0; b < BINS; b++) begin
            hist[b] <= hist[b] + CNT_W'(lane_cnt[b]);
          end
          grp <= (grp == LAST_G) ? '0 : grp + GRP_W'(1);
        end
        S_CDF: begin
          // bin wraps back to zero naturally after the last bin.
          cdf[bin] <= acc + hist[bin];
          acc      <= acc + hist[bin];
          bin      <= bin + PIX_W'(1);
        end
        S_MAP: begin
          for (int l = 0; l < LANES; l++) begin
            q_flat[lane_idx[l]] <= lane_map[l];
          end
          grp <= (grp == LAST_G) ? '0 : grp + GRP_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heu_lanes.sv
// tb/tb_heu_lanes.sv - self-checking bench for heu_lanes (default and 4x4 small instance)
module tb_heu_lanes;

  localparam int NPIX  = 400;
  localparam int SNPIX = 16;

  logic clk;
  logic rst_n;
  logic ipgu;
  logic rdn;
  logic in_ready;
  logic out_ready;
  logic [NPIX-1:0][7:0] fr;
  logic [NPIX-1:0][7:0] qf;

  logic s_ipgu;
  logic s_rdn;
  logic s_in_ready;
  logic s_out_ready;
  logic [SNPIX-1:0][3:0] sd;
  logic [SNPIX-1:0][3:0] sq;

`ifdef HEU_BYPASS_EN
  logic byp;
`endif

  int total;
  int bad;
  int m_in[NPIX];
  int m_out[NPIX];
  logic [NPIX-1:0][7:0] ef;
  logic [NPIX-1:0][7:0] snap;

  heu_lanes u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ipgu_out_ready (ipgu),
    .rdn_in_ready   (rdn),
    .d              (fr),
`ifdef HEU_BYPASS_EN
    .bypass         (byp),
`endif
    .in_ready       (in_ready),
    .out_ready      (out_ready),
    .q              (qf)
  );

  heu_lanes #(.PIX_W(4), .ROWS(4), .COLS(4), .LANES(2)) u_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .ipgu_out_ready (s_ipgu),
    .rdn_in_ready   (s_rdn),
    .d              (sd),
`ifdef HEU_BYPASS_EN
    .bypass         (1'b0),
`endif
    .in_ready       (s_in_ready),
    .out_ready      (s_out_ready),
    .q              (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: histogram, running sum, scaled floor division.
  function automatic void run_model(input int npix, input int pw);
    int h[256];
    int c[256];
    int acc;
    int maxv;
    maxv = (1 << pw) - 1;
    for (int b = 0; b < 256; b++) h[b] = 0;
    for (int i = 0; i < npix; i++) h[m_in[i]] = h[m_in[i]] + 1;
    acc = 0;
    for (int b = 0; b < (1 << pw); b++) begin
      acc  = acc + h[b];
      c[b] = acc;
    end
    for (int i = 0; i < npix; i++) m_out[i] = (c[m_in[i]] * maxv) / npix;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [NPIX-1:0][7:0] obs,
                           input logic [NPIX-1:0][7:0] exp);
    int fi;
    fi = 0;
    for (int i = NPIX - 1; i >= 0; i--) if (obs[i] !== exp[i]) fi = i;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s idx=%0d observed=%0h expected=%0h", tag, fi, obs[fi], exp[fi]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag);
    int lat;
    for (int i = 0; i < NPIX; i++) m_in[i] = int'(fr[i]);
    run_model(NPIX, 8);
    for (int i = 0; i < NPIX; i++) ef[i] = 8'(m_out[i]);
    ipgu = 1'b1;
    tick();
    ipgu = 1'b0;
    lat = 0;
    while (out_ready !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd416);
    chk_frame({tag, " q"}, qf, ef);
  endtask

  task automatic release_done(input int wait_cycles);
    repeat (wait_cycles) tick();
    rdn = 1'b1;
    tick();
    rdn = 1'b0;
    chk("release out_ready", 64'(out_ready), 64'd0);
    chk("release in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int mode;
    int a;
    int b;
    logic [SNPIX-1:0][3:0] sexp;

    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    ipgu   = 1'b0;
    rdn    = 1'b0;
    fr     = '0;
    s_ipgu = 1'b0;
    s_rdn  = 1'b0;
    sd     = '0;
`ifdef HEU_BYPASS_EN
    byp    = 1'b0;
`endif
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_ready", 64'(out_ready), 64'd0);
    chk_frame("reset q", qf, '0);
    rst_n = 1'b1;
    tick();

    // All-zero frame: every pixel lands in bin 0, cdf[0] = NPIX.
    fr = '0;
    run_frame("zero");
    chk("zero q0 const", 64'(qf[0]), 64'hFF);
    release_done(1);

    // Two halves, every lane group fully colliding.
    for (int i = 0; i < NPIX; i++) fr[i] = (i < 200) ? 8'h10 : 8'h80;
    run_frame("halves");
    chk("halves q0 const", 64'(qf[0]), 64'h7F);
    chk("halves q399 const", 64'(qf[399]), 64'hFF);
    release_done(3);

    // Random frames with a mix of value distributions.
    for (int n = 0; n < 50; n++) begin
      mode = n % 4;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      for (int i = 0; i < NPIX; i++) begin
        case (mode)
          0: fr[i] = 8'($urandom_range(0, 255));
          1: fr[i] = 8'($urandom_range(0, 7));
          2: fr[i] = ($urandom_range(0, 1) == 0) ? 8'(a) : 8'(b);
          default: fr[i] = 8'($urandom_range(248, 255));
        endcase
      end
      run_frame("random");
      release_done(3);
    end

    // Hold in DONE: extra starts and changing d must not disturb q.
    for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom_range(0, 255));
    run_frame("hold");
    snap = qf;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom_range(0, 255));
      ipgu = (k % 2 == 0);
      tick();
      chk("hold out_ready", 64'(out_ready), 64'd1);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      chk_frame("hold q", qf, snap);
    end
    // Release together with a start: the start must be ignored.
    rdn  = 1'b1;
    ipgu = 1'b1;
    tick();
    rdn  = 1'b0;
    ipgu = 1'b0;
    chk("release+start in_ready", 64'(in_ready), 64'd1);
    chk("release+start out_ready", 64'(out_ready), 64'd0);
    tick();
    chk("ignored start in_ready", 64'(in_ready), 64'd1);
    chk_frame("idle q kept", qf, snap);

    // Reset during MAP, group 40.
    for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom_range(0, 255));
    ipgu = 1'b1;
    tick();
    ipgu = 1'b0;
    repeat (80 + 256 + 40) tick();
    rst_n = 1'b0;
    #1;
    chk("abort out_ready", 64'(out_ready), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk_frame("abort q", qf, '0);
    tick();
    rst_n = 1'b1;
    tick();
    run_frame("after abort");
    release_done(1);

`ifdef HEU_BYPASS_EN
    for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom_range(0, 255));
    ef   = fr;
    byp  = 1'b1;
    ipgu = 1'b1;
    tick();
    ipgu = 1'b0;
    byp  = 1'b0;
    lat  = 0;
    while (out_ready !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
    end
    chk("bypass latency", 64'(lat), 64'd0);
    chk_frame("bypass q", qf, ef);
    release_done(1);
    for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom_range(0, 255));
    run_frame("post bypass");
    release_done(1);
`endif

    // Small instance: 4-bit pixels, 4x4 frame, 2 lanes.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < SNPIX; i++) begin
        sd[i]   = (n == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        m_in[i] = int'(sd[i]);
      end
      run_model(SNPIX, 4);
      for (int i = 0; i < SNPIX; i++) sexp[i] = 4'(m_out[i]);
      s_ipgu = 1'b1;
      tick();
      s_ipgu = 1'b0;
      lat = 0;
      while (s_out_ready !== 1'b1 && lat < 500) begin
        tick();
        lat++;
      end
      chk("small latency", 64'(lat), 64'd32);
      chk("small q", 64'(sq), 64'(sexp));
      s_rdn = 1'b1;
      tick();
      s_rdn = 1'b0;
      chk("small in_ready", 64'(s_in_ready), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
